// File: rtl/iob_split_tmo.sv
// ============================================================================
// iob_split_tmo : IOb native bus splitter with decode-error, timeout abort and
//                 sticky error status.  Revision 1.0
// ============================================================================
`default_nettype none

module iob_split_tmo #(
  parameter int                N_SLAVES = 4,
  parameter int                P_SLAVES = 30,
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TMO_W    = 8,
  parameter int                TMO_EN   = 1,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [ADDR_W+DATA_W+DATA_W/8:0]                    m_req,
  output logic [DATA_W:0]                                    m_resp,
  output logic [N_SLAVES*(1+ADDR_W+DATA_W+DATA_W/8)-1:0]     s_req,
  input  logic [N_SLAVES*(DATA_W+1)-1:0]                     s_resp,
  input  logic                                               err_clr,
  output logic [1:0]                                         err_code,
  output logic [ADDR_W-1:0]                                  err_addr,
  output logic [7:0]                                         err_cnt,
  output logic                                               err_pulse
);

  localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W/8;
  localparam int RESP_W = DATA_W + 1;
  localparam int SEL_W  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  localparam logic [1:0]       S_IDLE  = 2'd0;
  localparam logic [1:0]       S_WAIT  = 2'd1;
  localparam logic [1:0]       S_DERR  = 2'd2;
  localparam logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}};
  localparam logic [SEL_W:0]   N_SEL   = (SEL_W+1)'(N_SLAVES);

  logic [1:0]        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic                w_m_valid;
  logic [ADDR_W-1:0]   w_addr;
  logic [SEL_W-1:0]    w_idx;
  logic                w_mapped;
  logic [SEL_W-1:0]    w_sel;
  logic [N_SLAVES-1:0] w_onehot;
  logic                w_sel_ready;
  logic [DATA_W-1:0]   w_sel_rdata;
  logic                w_tmo;
  logic [N_SLAVES-1:0] w_s_valid;
  logic                w_m_ready;
  logic [DATA_W-1:0]   w_m_rdata;
  logic                w_err_evt;
  logic [1:0]          w_err_set;

  assign w_m_valid = m_req[REQ_W-1];
  assign w_addr    = m_req[REQ_W-2 -: ADDR_W];
  assign w_idx     = w_addr[P_SLAVES -: SEL_W];
  assign w_mapped  = ({1'b0, w_idx} < N_SEL);
  assign w_sel     = (state_q == S_IDLE) ? w_idx : sel_q;
  assign w_tmo     = (TMO_EN != 0) && (tmo_cnt_q == TMO_MAX);

  // Only the valid bit is steered; address/wdata/wstrb go to every slave.
  for (genvar g = 0; g < N_SLAVES; g++) begin : g_slave
    assign s_req[g*REQ_W +: REQ_W] = {w_s_valid[g], m_req[REQ_W-2:0]};
  end

  always_comb begin
    w_onehot    = '0;
    w_sel_ready = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (SEL_W'(i) == w_sel) begin
        w_onehot[i] = 1'b1;
        w_sel_ready = s_resp[i*RESP_W];
        w_sel_rdata = s_resp[i*RESP_W+1 +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      tmo_cnt_q  <= '0;
      err_code_q <= 2'b00;
      err_addr_q <= '0;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      tmo_cnt_q  <= tmo_cnt_d;
      err_code_q <= err_code_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    tmo_cnt_d  = tmo_cnt_q;
    err_code_d = err_code_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_m_valid) begin
          if (w_mapped) begin
            sel_d = w_idx;
            if (!w_sel_ready) begin
              state_d   = S_WAIT;
              tmo_cnt_d = TMO_W'(1);
            end
          end else begin
            state_d = S_DERR;
          end
        end
      end
      S_WAIT: begin
        if (w_sel_ready || w_tmo) state_d = S_IDLE;
        else                      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
      S_DERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A clear in the same cycle as an error wins; the error is not recorded.
    if (err_clr) begin
      err_code_d = 2'b00;
      err_addr_d = '0;
      err_cnt_d  = 8'd0;
    end else if (w_err_evt) begin
      err_code_d = err_code_q | w_err_set;
      err_addr_d = w_addr;
      err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
    end
  end

  always_comb begin
    w_s_valid = '0;
    w_m_ready = 1'b0;
    w_m_rdata = '0;
    w_err_evt = 1'b0;
    w_err_set = 2'b00;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (w_m_valid && w_mapped) begin
            w_s_valid = w_onehot;
            if (w_sel_ready) begin
              w_m_ready = 1'b1;
              w_m_rdata = w_sel_rdata;
            end
          end
        end
        S_WAIT: begin
          if (w_sel_ready) begin
            w_s_valid = w_onehot;
            w_m_ready = 1'b1;
            w_m_rdata = w_sel_rdata;
          end else if (w_tmo) begin
            w_m_ready = 1'b1;
            w_m_rdata = ERR_DATA;
            w_err_evt = 1'b1;
            w_err_set = 2'b10;
          end else begin
            w_s_valid = w_onehot;
          end
        end
        S_DERR: begin
          w_m_ready = 1'b1;
          w_m_rdata = ERR_DATA;
          w_err_evt = 1'b1;
          w_err_set = 2'b01;
        end
        default: ;
      endcase
    end
  end

  assign m_resp    = {w_m_rdata, w_m_ready};
  assign err_code  = err_code_q;
  assign err_addr  = err_addr_q;
  assign err_cnt   = err_cnt_q;
  assign err_pulse = w_err_evt;

endmodule

`default_nettype wire

// File: tb/tb_iob_split_tmo.sv
// ============================================================================
// tb_iob_split_tmo : self-checking bench for iob_split_tmo (3 slaves, 4-bit
//                    timeout).  Revision 1.0
// ============================================================================
`default_nettype none

module tb_iob_split_tmo;

  localparam int NS     = 3;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int TW     = 4;
  localparam int REQ_W  = 1 + AW + DW + DW/8;
  localparam int RESP_W = DW + 1;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [REQ_W-1:0]     m_req = '0;
  logic [RESP_W-1:0]    m_resp;
  logic [NS*REQ_W-1:0]  s_req;
  logic [NS*RESP_W-1:0] s_resp = '0;
  logic                 err_clr = 1'b0;
  logic [1:0]           err_code;
  logic [AW-1:0]        err_addr;
  logic [7:0]           err_cnt;
  logic                 err_pulse;

  always #5 clk = ~clk;

  iob_split_tmo #(
    .N_SLAVES(NS), .P_SLAVES(30), .ADDR_W(AW), .DATA_W(DW),
    .TMO_W(TW), .TMO_EN(1), .ERR_DATA(ERRD)
  ) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_resp(m_resp), .s_req(s_req),
    .s_resp(s_resp), .err_clr(err_clr), .err_code(err_code),
    .err_addr(err_addr), .err_cnt(err_cnt), .err_pulse(err_pulse)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference status: what the sticky error registers should hold.
  logic [1:0]  mdl_code = 2'b00;
  logic [31:0] mdl_addr = '0;
  int          mdl_cnt  = 0;
  logic [31:0] last_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [NS-1:0] s_valid_vec();
    logic [NS-1:0] v;
    for (int j = 0; j < NS; j++) v[j] = s_req[j*REQ_W + REQ_W-1];
    return v;
  endfunction

  // Transaction outcome from the rules: slave latency lat means ready on
  // cycle lat+1; WAIT gives up on cycle 16; unmapped index answers on cycle 2.
  function automatic int exp_cycles(input logic [1:0] idx, input int lat);
    if (idx >= 2'(NS)) return 2;
    return (lat + 1 <= 16) ? lat + 1 : 16;
  endfunction

  function automatic bit is_err(input logic [1:0] idx, input int lat);
    return (idx >= 2'(NS)) || (lat + 1 > 16);
  endfunction

  task automatic mdl_update(input logic [1:0] idx, input int lat, input int clr_c, input int cyc);
    if (clr_c > 0 && clr_c <= cyc) begin
      mdl_code = 2'b00; mdl_addr = '0; mdl_cnt = 0;
    end
    if (is_err(idx, lat) && clr_c != cyc) begin
      mdl_code = mdl_code | ((idx >= 2'(NS)) ? 2'b01 : 2'b10);
      mdl_addr = last_addr;
      if (mdl_cnt < 255) mdl_cnt++;
    end
  endtask

  task automatic idle_cycle(input bit noise, input logic [NS-1:0] force_rdy, input bit clr);
    @(negedge clk);
    m_req   = '0;
    err_clr = clr;
    for (int j = 0; j < NS; j++)
      s_resp[j*RESP_W +: RESP_W] = {$urandom, force_rdy[j] | (noise & 1'($urandom))};
    #1;
    check("idle_svalid", 64'(s_valid_vec()), 64'h0);
    check("idle_mresp", {m_resp, err_pulse}, 64'h0);
  endtask

  task automatic do_txn(input logic [1:0] idx, input int lat, input logic [31:0] sdata,
                        input bit noise, input int clr_c,
                        output int cyc, output logic [31:0] rdata, output logic pulse);
    logic [31:0]   addr;
    logic [31:0]   wd;
    logic [3:0]    ws;
    logic [NS-1:0] exp_v;
    bit            abort;
    addr = $urandom;
    addr[30:29] = idx;
    wd = $urandom;
    ws = 4'($urandom);
    last_addr = addr;
    abort = (idx < 2'(NS)) && (lat + 1 > 16);
    cyc = -1; rdata = '0; pulse = 1'b0;
    for (int c = 1; c <= 40 && cyc < 0; c++) begin
      @(negedge clk);
      m_req   = {1'b1, addr, wd, ws};
      err_clr = (c == clr_c);
      for (int j = 0; j < NS; j++) begin
        logic rdy;
        rdy = (2'(j) == idx) ? (c == lat + 1) : (noise & 1'($urandom));
        s_resp[j*RESP_W +: RESP_W] = {((2'(j) == idx && rdy) ? sdata : $urandom), rdy};
      end
      #1;
      if (c == 1) begin
        check("err_code", 64'(err_code), 64'(mdl_code));
        check("err_cnt", 64'(err_cnt), 64'(mdl_cnt));
        check("err_addr", 64'(err_addr), 64'(mdl_addr));
      end
      exp_v = '0;
      if (idx < 2'(NS) && !(abort && c == 16)) exp_v = NS'(1) << idx;
      check("s_valid", 64'(s_valid_vec()), 64'(exp_v));
      check("bcast_addr", 64'(s_req[REQ_W + DW + DW/8 +: AW]), 64'(addr));
      if (m_resp[0]) begin
        cyc = c; rdata = m_resp[RESP_W-1:1]; pulse = err_pulse;
      end else begin
        check("noready_out", {m_resp, err_pulse}, 64'h0);
      end
    end
  endtask

  typedef struct {
    logic [1:0]  idx;
    int          lat;
    logic [31:0] sdata;
    int          exp_cyc;
    logic [31:0] exp_data;
    logic        exp_pulse;
    logic [1:0]  exp_code;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int          cyc;
    logic [31:0] rd;
    logic        pl;

    tbl[0] = '{2'd2,  0, 32'h12345678,  1, 32'h12345678, 1'b0, 2'b00, 8'd0};
    tbl[1] = '{2'd1,  5, 32'hCAFEF00D,  6, 32'hCAFEF00D, 1'b0, 2'b00, 8'd0};
    tbl[2] = '{2'd3,  0, 32'h00000000,  2, ERRD,         1'b1, 2'b01, 8'd1};
    tbl[3] = '{2'd0, 99, 32'h11111111, 16, ERRD,         1'b1, 2'b11, 8'd2};
    tbl[4] = '{2'd0, 15, 32'h0BADC0DE, 16, 32'h0BADC0DE, 1'b0, 2'b11, 8'd2};
    tbl[5] = '{2'd1, 14, 32'h5A5A5A5A, 15, 32'h5A5A5A5A, 1'b0, 2'b11, 8'd2};
    tbl[6] = '{2'd2, 16, 32'h77777777, 16, ERRD,         1'b1, 2'b11, 8'd3};

    // Reset state
    repeat (2) @(negedge clk);
    s_resp = '1;
    m_req  = {1'b1, {(REQ_W-1){1'b0}}};
    #1;
    check("rst_svalid", 64'(s_valid_vec()), 64'h0);
    check("rst_mresp", {m_resp, err_pulse}, 64'h0);
    @(negedge clk);
    rst = 1'b0; m_req = '0; s_resp = '0;
    #1;
    check("rst_status", {err_code, err_cnt, err_addr}, 64'h0);

    for (int k = 0; k < 7; k++) begin
      do_txn(tbl[k].idx, tbl[k].lat, tbl[k].sdata, 1'b1, 0, cyc, rd, pl);
      check("tbl_cycles", 64'(cyc), 64'(tbl[k].exp_cyc));
      check("tbl_rdata", 64'(rd), 64'(tbl[k].exp_data));
      check("tbl_pulse", 64'(pl), 64'(tbl[k].exp_pulse));
      mdl_update(tbl[k].idx, tbl[k].lat, 0, cyc);
      idle_cycle(1'b1, '0, 1'b0);
      check("tbl_code", 64'(err_code), 64'(tbl[k].exp_code));
      check("tbl_cnt", 64'(err_cnt), 64'(tbl[k].exp_cnt));
      if (tbl[k].exp_pulse) check("tbl_addr", 64'(err_addr), 64'(last_addr));
    end

    // Abort, then the aborted slave answers late: must not reach the master.
    do_txn(2'd0, 99, 32'h0, 1'b0, 0, cyc, rd, pl);
    check("abort_cycles", 64'(cyc), 64'd16);
    check("abort_rdata", 64'(rd), 64'(ERRD));
    mdl_update(2'd0, 99, 0, cyc);
    idle_cycle(1'b0, '0, 1'b0);
    idle_cycle(1'b0, '0, 1'b0);
    idle_cycle(1'b0, 3'b001, 1'b0);

    // Clear coinciding with a decode-error termination drops the error.
    do_txn(2'd3, 0, 32'h0, 1'b0, 2, cyc, rd, pl);
    check("clr_cycles", 64'(cyc), 64'd2);
    mdl_update(2'd3, 0, 2, cyc);
    idle_cycle(1'b0, '0, 1'b0);
    check("clr_prio", {err_code, err_cnt, err_addr}, 64'h0);

    // Counter saturation and clear.
    for (int k = 0; k < 300; k++) begin
      do_txn(2'd3, 0, 32'h0, 1'b0, 0, cyc, rd, pl);
      mdl_update(2'd3, 0, 0, cyc);
    end
    idle_cycle(1'b0, '0, 1'b0);
    check("sat_cnt", 64'(err_cnt), 64'd255);
    check("sat_code", 64'(err_code), 64'd1);
    idle_cycle(1'b0, '0, 1'b1);
    idle_cycle(1'b0, '0, 1'b0);
    check("clr_all", {err_code, err_cnt, err_addr}, 64'h0);
    mdl_code = 2'b00; mdl_addr = '0; mdl_cnt = 0;

    // Reset while waiting, with the selected slave answering during reset.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      m_req = {1'b1, 32'h2000_0040, 32'h0, 4'h0};
      s_resp = '0;
    end
    @(negedge clk);
    rst = 1'b1;
    s_resp[RESP_W +: RESP_W] = {32'h01020304, 1'b1};
    #1;
    check("rstw_svalid", 64'(s_valid_vec()), 64'h0);
    check("rstw_mresp", 64'(m_resp), 64'h0);
    @(negedge clk);
    rst = 1'b0; m_req = '0;
    #1;
    check("rstw_idle_svalid", 64'(s_valid_vec()), 64'h0);
    check("rstw_idle_mresp", 64'(m_resp), 64'h0);

    // Randomized traffic against the rule-level model.
    for (int k = 0; k < 150; k++) begin
      logic [1:0]  idx;
      int          lat;
      logic [31:0] sd;
      idx = 2'($urandom_range(0, 3));
      lat = $urandom_range(0, 20);
      sd  = $urandom;
      do_txn(idx, lat, sd, 1'b1, 0, cyc, rd, pl);
      check("rnd_cycles", 64'(cyc), 64'(exp_cycles(idx, lat)));
      check("rnd_rdata", 64'(rd), 64'(is_err(idx, lat) ? ERRD : sd));
      check("rnd_pulse", 64'(pl), 64'(is_err(idx, lat)));
      mdl_update(idx, lat, 0, cyc);
      repeat ($urandom_range(0, 2)) idle_cycle(1'b1, '0, 1'b0);
    end
    idle_cycle(1'b0, '0, 1'b0);
    check("final_code", 64'(err_code), 64'(mdl_code));
    check("final_cnt", 64'(err_cnt), 64'(mdl_cnt));
    check("final_addr", 64'(err_addr), 64'(mdl_addr));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
